// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin arbiter sharing one DRAM port between two requesters
module dram_arbiter #(
   parameter int AW     = 16,
   parameter int DW     = 16,
   parameter int RD_LAT = 1
) (
   input  logic          Clk1,
   input  logic          Reset,
   input  logic          Req0,
   input  logic          Req1,
   input  logic          RD0,
   input  logic          RD1,
   input  logic          WR0,
   input  logic          WR1,
   input  logic [AW-1:0] Addr0,
   input  logic [AW-1:0] Addr1,
   input  logic [DW-1:0] WData0,
   input  logic [DW-1:0] WData1,
   output logic          Ack0,
   output logic          Ack1,
   output logic [DW-1:0] RData0,
   output logic [DW-1:0] RData1,
   output logic [AW-1:0] MemAddr,
   output logic          MemRD,
   output logic          MemWR,
   output logic [DW-1:0] MemWData,
   input  logic [DW-1:0] MemRData,
   output logic          Busy,
   output logic          GntId
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   typedef enum logic [1:0] {OP_NOP, OP_RD, OP_WR} op_t;

   localparam logic [2:0] LAT = RD_LAT[2:0];

   state_t     state, state_nxt;
   op_t        op;
   logic       last;
   logic [2:0] cnt;
   logic       win, win_rd, win_wr, capture;

   // A tie goes to the port that was not served last.
   always_comb begin
      win    = (Req0 && Req1) ? ~last : Req1;
      win_rd = win ? RD1 : RD0;
      win_wr = win ? WR1 : WR0;
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         IDLE:  if (Req0 || Req1) state_nxt = ISSUE;
         ISSUE: begin
            if (op == OP_RD && LAT != 3'd0) begin
               state_nxt = WAIT;
            end else begin
               state_nxt = DONE;
               capture   = (op == OP_RD);
            end
         end
         WAIT: begin
            if (cnt == LAT) begin
               state_nxt = DONE;
               capture   = 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk1) begin
      if (Reset) begin
         state    <= IDLE;
         op       <= OP_NOP;
         last     <= 1'b1;
         cnt      <= 3'd0;
         Ack0     <= 1'b0;
         Ack1     <= 1'b0;
         RData0   <= '0;
         RData1   <= '0;
         MemAddr  <= '0;
         MemRD    <= 1'b0;
         MemWR    <= 1'b0;
         MemWData <= '0;
         Busy     <= 1'b0;
         GntId    <= 1'b0;
      end else begin
         state <= state_nxt;
         Busy  <= (state_nxt != IDLE);
         MemRD <= 1'b0;
         MemWR <= 1'b0;
         Ack0  <= 1'b0;
         Ack1  <= 1'b0;
         // Strobes are registered, so they are launched on the edge that enters ISSUE.
         if (state == IDLE && state_nxt == ISSUE) begin
            GntId    <= win;
            last     <= win;
            MemAddr  <= win ? Addr1 : Addr0;
            MemWData <= win ? WData1 : WData0;
            op       <= win_wr ? OP_WR : (win_rd ? OP_RD : OP_NOP);
            MemWR    <= win_wr;
            MemRD    <= win_rd & ~win_wr;
            cnt      <= 3'd1;
         end
         if (state == WAIT) cnt <= cnt + 3'd1;
         if (capture) begin
            if (GntId) RData1 <= MemRData;
            else       RData0 <= MemRData;
         end
         if (state_nxt == DONE) begin
            Ack0 <= ~GntId;
            Ack1 <= GntId;
         end
      end
   end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - self-checking bench for dram_arbiter with DRAM and reference models
module tb_dram_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req0, req1, rd0, rd1, wr0, wr1;
   logic [15:0] addr0, addr1, wdata0, wdata1;
   logic        ack0, ack1, mrd, mwr, busy, gnt;
   logic [15:0] rdata0, rdata1, maddr, mwdata, mrdata;

   logic        b_req0, b_req1, b_rd0, b_rd1, b_wr0, b_wr1;
   logic [15:0] b_addr0, b_addr1, b_wdata0, b_wdata1;
   logic        b_ack0, b_ack1, b_mrd, b_mwr, b_busy, b_gnt;
   logic [15:0] b_rdata0, b_rdata1, b_maddr, b_mwdata, b_mrdata;

   dram_arbiter #(.AW(16), .DW(16), .RD_LAT(1)) u_dut (
      .Clk1(clk), .Reset(rst), .Req0(req0), .Req1(req1), .RD0(rd0), .RD1(rd1),
      .WR0(wr0), .WR1(wr1), .Addr0(addr0), .Addr1(addr1), .WData0(wdata0), .WData1(wdata1),
      .Ack0(ack0), .Ack1(ack1), .RData0(rdata0), .RData1(rdata1), .MemAddr(maddr),
      .MemRD(mrd), .MemWR(mwr), .MemWData(mwdata), .MemRData(mrdata), .Busy(busy), .GntId(gnt));

   dram_arbiter #(.AW(16), .DW(16), .RD_LAT(0)) u_dut0 (
      .Clk1(clk), .Reset(rst), .Req0(b_req0), .Req1(b_req1), .RD0(b_rd0), .RD1(b_rd1),
      .WR0(b_wr0), .WR1(b_wr1), .Addr0(b_addr0), .Addr1(b_addr1), .WData0(b_wdata0),
      .WData1(b_wdata1), .Ack0(b_ack0), .Ack1(b_ack1), .RData0(b_rdata0), .RData1(b_rdata1),
      .MemAddr(b_maddr), .MemRD(b_mrd), .MemWR(b_mwr), .MemWData(b_mwdata),
      .MemRData(b_mrdata), .Busy(b_busy), .GntId(b_gnt));

   // DRAM models: one-cycle latency (junk when not reading) and zero latency.
   bit [15:0] mem  [0:255];
   bit [15:0] memb [0:255];
   always @(posedge clk) begin
      if (mwr) mem[maddr[7:0]] <= mwdata;
      if (mrd) mrdata <= mem[maddr[7:0]];
      else     mrdata <= 16'($urandom);
      if (b_mwr) memb[b_maddr[7:0]] <= b_mwdata;
   end
   assign b_mrdata = b_mrd ? memb[b_maddr[7:0]] : 16'hDEAD;

   int errors = 0;
   int checks = 0;

   // Reference model: memory image, last-served port, per-port read data.
   bit [15:0]   refm [0:255];
   bit          last_m = 1'b1;
   logic [15:0] rd_m [2];

   int          res_n, res_nrd, res_nwr;
   int          res_lat [2];
   bit          res_port [2];
   logic [15:0] res_rd [2];
   logic [15:0] res_addr, res_wdata;
   logic        res_gnt1;
   bit          res_wide;

   function automatic int lat_of(input bit p);
      bit w = p ? wr1 : wr0;
      bit r = p ? rd1 : rd0;
      return w ? 2 : (r ? 3 : 2);
   endfunction

   task automatic serve(input bit p);
      bit          w = p ? wr1 : wr0;
      bit          r = p ? rd1 : rd0;
      logic [15:0] a = p ? addr1 : addr0;
      logic [15:0] d = p ? wdata1 : wdata0;
      if (w)      refm[a[7:0]] = d;
      else if (r) rd_m[p] = refm[a[7:0]];
      last_m = p;
   endtask

   task automatic go(input bit e0, input bit e1);
      bit prev = 1'b0;
      int need = int'(e0) + int'(e1);
      res_n = 0; res_nrd = 0; res_nwr = 0; res_wide = 1'b0;
      req0 = e0; req1 = e1;
      for (int c = 1; c <= 40 && res_n < need; c++) begin
         @(negedge clk);
         if (c == 1) res_gnt1 = gnt;
         if (mwr) begin res_nwr++; res_addr = maddr; res_wdata = mwdata; end
         if (mrd) begin res_nrd++; res_addr = maddr; end
         if (ack0 || ack1) begin
            if (prev || (ack0 && ack1)) res_wide = 1'b1;
            res_lat[res_n]  = c;
            res_port[res_n] = ack1;
            res_rd[res_n]   = ack1 ? rdata1 : rdata0;
            if (ack1) req1 = 1'b0; else req0 = 1'b0;
            res_n++;
         end
         prev = ack0 || ack1;
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      if (ack0 || ack1) res_wide = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({ack0, ack1, mrd, mwr, busy, gnt} !== 6'b0 || rdata0 !== 16'h0 || rdata1 !== 16'h0 ||
          maddr !== 16'h0 || mwdata !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs: got ack=%b%b rd=%b wr=%b busy=%b gnt=%b rdata=%h/%h addr=%h wdata=%h, want all 0",
                  ack0, ack1, mrd, mwr, busy, gnt, rdata0, rdata1, maddr, mwdata);
      end
      rd0 = 0; wr0 = 1; addr0 = 16'h0001; wdata0 = 16'($urandom);
      rd1 = 0; wr1 = 1; addr1 = 16'h0002; wdata1 = 16'($urandom);
      serve(0); serve(1);
      go(1, 1);
      checks++;
      if (res_gnt1 !== 1'b0) begin
         errors++; $display("FAIL reset_first_gnt: got %b want 0", res_gnt1);
      end
      checks++;
      if (res_n != 2 || res_port[0] !== 1'b0 || res_port[1] !== 1'b1 || res_lat[0] != 2 || res_lat[1] != 5) begin
         errors++;
         $display("FAIL reset_tie_order: got n=%0d ports=%b,%b lat=%0d,%0d want 2 ports 0,1 lat 2,5",
                  res_n, res_port[0], res_port[1], res_lat[0], res_lat[1]);
      end
   endtask

   task automatic test_write();
      rd0 = 0; wr0 = 1; addr0 = 16'h0010; wdata0 = 16'hBEEF;
      serve(0);
      go(1, 0);
      checks++;
      if (res_nwr != 1 || res_nrd != 0 || res_addr !== 16'h0010 || res_wdata !== 16'hBEEF) begin
         errors++;
         $display("FAIL write_strobe: got nwr=%0d nrd=%0d addr=%h data=%h want 1 0 0010 beef",
                  res_nwr, res_nrd, res_addr, res_wdata);
      end
      checks++;
      if (res_n != 1 || res_lat[0] != 2 || res_port[0] !== 1'b0 || res_wide) begin
         errors++; $display("FAIL write_ack: got n=%0d lat=%0d port=%b wide=%b want 1 2 0 0",
                            res_n, res_lat[0], res_port[0], res_wide);
      end
      checks++;
      if (mem[8'h10] !== 16'hBEEF) begin
         errors++; $display("FAIL write_dram: got %h want beef", mem[8'h10]);
      end
   endtask

   task automatic test_read();
      logic [15:0] r0 = rdata0;
      rd1 = 1; wr1 = 0; addr1 = 16'h0010;
      serve(1);
      go(0, 1);
      checks++;
      if (res_n != 1 || res_lat[0] != 3 || res_nrd != 1 || res_nwr != 0 || res_port[0] !== 1'b1) begin
         errors++; $display("FAIL read_ack: got n=%0d lat=%0d nrd=%0d nwr=%0d port=%b want 1 3 1 0 1",
                            res_n, res_lat[0], res_nrd, res_nwr, res_port[0]);
      end
      checks++;
      if (res_rd[0] !== 16'hBEEF || rdata1 !== 16'hBEEF || rdata0 !== r0) begin
         errors++; $display("FAIL read_data: got ack-time=%h rdata1=%h rdata0=%h want beef beef %h",
                            res_rd[0], rdata1, rdata0, r0);
      end
   endtask

   task automatic test_alternation();
      bit exp_p = ~last_m;
      bit prev = 1'b0;
      int n = 0;
      rd0 = 0; wr0 = 1; addr0 = 16'h0020; wdata0 = 16'($urandom);
      rd1 = 0; wr1 = 1; addr1 = 16'h0021; wdata1 = 16'($urandom);
      req0 = 1; req1 = 1;
      for (int c = 0; c < 60 && n < 6; c++) begin
         @(negedge clk);
         if (ack0 || ack1) begin
            checks++;
            if (ack1 !== exp_p || gnt !== exp_p || prev || (ack0 && ack1)) begin
               errors++; $display("FAIL alternation_%0d: got ack=%b%b gnt=%b prev=%b want port %b single pulse",
                                  n, ack1, ack0, gnt, prev, exp_p);
            end
            serve(exp_p);
            exp_p = ~exp_p;
            n++;
            if (n == 6) begin req0 = 0; req1 = 0; end
         end
         prev = ack0 || ack1;
      end
      req0 = 0; req1 = 0;
      checks++;
      if (n != 6) begin
         errors++; $display("FAIL alternation_count: got %0d acks want 6", n);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      rd0 = 1; wr0 = 0; addr0 = 16'h0010;
      req0 = 1;
      repeat (2) @(negedge clk);
      rst = 1; req0 = 0;
      @(negedge clk);
      checks++;
      if (ack0 !== 1'b0 || mrd !== 1'b0 || mwr !== 1'b0 || busy !== 1'b0 || rdata0 !== 16'h0 || gnt !== 1'b0) begin
         errors++; $display("FAIL reset_mid: got ack0=%b rd=%b wr=%b busy=%b rdata0=%h gnt=%b want all 0",
                            ack0, mrd, mwr, busy, rdata0, gnt);
      end
      rst = 0;
      last_m = 1'b1; rd_m[0] = 16'h0; rd_m[1] = 16'h0;
      serve(0);
      go(1, 0);
      checks++;
      if (res_n != 1 || res_lat[0] != 3 || rdata0 !== 16'hBEEF) begin
         errors++; $display("FAIL reset_mid_recover: got n=%0d lat=%0d rdata0=%h want 1 3 beef",
                            res_n, res_lat[0], rdata0);
      end
   endtask

   task automatic test_opcode();
      rd0 = 1; wr0 = 1; addr0 = 16'h0030; wdata0 = 16'($urandom);
      serve(0);
      go(1, 0);
      checks++;
      if (res_nwr != 1 || res_nrd != 0 || res_lat[0] != 2 || mem[8'h30] !== wdata0) begin
         errors++; $display("FAIL rdwr_is_write: got nwr=%0d nrd=%0d lat=%0d mem=%h want 1 0 2 %h",
                            res_nwr, res_nrd, res_lat[0], mem[8'h30], wdata0);
      end
      rd0 = 0; wr0 = 0;
      serve(0);
      go(1, 0);
      checks++;
      if (res_nwr != 0 || res_nrd != 0 || res_n != 1 || res_lat[0] != 2 || res_port[0] !== 1'b0) begin
         errors++; $display("FAIL noop: got nwr=%0d nrd=%0d n=%0d lat=%0d port=%b want 0 0 1 2 0",
                            res_nwr, res_nrd, res_n, res_lat[0], res_port[0]);
      end
   endtask

   task automatic test_rdlat0();
      int lat = -1;
      int nrd = 0;
      b_wr0 = 1; b_rd0 = 0; b_addr0 = 16'h0010; b_wdata0 = 16'hBEEF; b_req0 = 1;
      for (int c = 1; c <= 10 && lat < 0; c++) begin
         @(negedge clk);
         if (b_ack0) lat = c;
      end
      b_req0 = 0;
      @(negedge clk);
      checks++;
      if (lat != 2 || memb[8'h10] !== 16'hBEEF) begin
         errors++; $display("FAIL lat0_write: got lat=%0d mem=%h want 2 beef", lat, memb[8'h10]);
      end
      lat = -1;
      b_rd1 = 1; b_wr1 = 0; b_addr1 = 16'h0010; b_req1 = 1;
      for (int c = 1; c <= 10 && lat < 0; c++) begin
         @(negedge clk);
         if (b_mrd) nrd++;
         if (b_ack1) lat = c;
      end
      b_req1 = 0;
      checks++;
      if (lat != 2 || nrd != 1 || b_rdata1 !== 16'hBEEF || b_rdata0 !== 16'h0) begin
         errors++; $display("FAIL lat0_read: got lat=%0d nrd=%0d rdata1=%h rdata0=%h want 2 1 beef 0000",
                            lat, nrd, b_rdata1, b_rdata0);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         int          mode = $urandom_range(0, 2);
         bit          e0 = (mode != 1);
         bit          e1 = (mode != 0);
         bit          first;
         int          l1, l2;
         logic [15:0] x1, x2;
         rd0 = 1'($urandom); wr0 = 1'($urandom); addr0 = 16'($urandom_range(0, 31)); wdata0 = 16'($urandom);
         rd1 = 1'($urandom); wr1 = 1'($urandom); addr1 = 16'($urandom_range(0, 31)); wdata1 = 16'($urandom);
         first = (e0 && e1) ? ~last_m : e1;
         l1 = lat_of(first); serve(first); x1 = rd_m[first];
         l2 = 0; x2 = 16'h0;
         if (e0 && e1) begin
            l2 = l1 + 1 + lat_of(~first); serve(~first); x2 = rd_m[~first];
         end
         go(e0, e1);
         checks++;
         if (res_n != int'(e0) + int'(e1) || res_port[0] !== first || res_lat[0] != l1 ||
             res_rd[0] !== x1 || res_wide) begin
            errors++; $display("FAIL rand_%0d_first: got n=%0d port=%b lat=%0d data=%h wide=%b want port %b lat %0d data %h",
                               i, res_n, res_port[0], res_lat[0], res_rd[0], res_wide, first, l1, x1);
         end
         if (e0 && e1) begin
            checks++;
            if (res_port[1] !== ~first || res_lat[1] != l2 || res_rd[1] !== x2) begin
               errors++; $display("FAIL rand_%0d_second: got port=%b lat=%0d data=%h want %b %0d %h",
                                  i, res_port[1], res_lat[1], res_rd[1], ~first, l2, x2);
            end
         end
         checks++;
         if (rdata0 !== rd_m[0] || rdata1 !== rd_m[1]) begin
            errors++; $display("FAIL rand_%0d_rdata: got %h/%h want %h/%h", i, rdata0, rdata1, rd_m[0], rd_m[1]);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      req0 = 0; req1 = 0; rd0 = 0; rd1 = 0; wr0 = 0; wr1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      b_req0 = 0; b_req1 = 0; b_rd0 = 0; b_rd1 = 0; b_wr0 = 0; b_wr1 = 0;
      b_addr0 = 0; b_addr1 = 0; b_wdata0 = 0; b_wdata1 = 0;
      rd_m[0] = 16'h0; rd_m[1] = 16'h0;
      @(negedge clk);
      test_reset();
      test_write();
      test_read();
      test_alternation();
      test_reset_mid();
      test_opcode();
      test_rdlat0();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
